alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/result width; legal range 4..64.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports in_1, in_2  input  WIDTH  operands, sampled only on accepted start.
REQ-005 SHALL have port select  input  4  opcode, sampled with operands.
REQ-006 SHALL have port carry_in  input  1  carry for ADD, sampled with operands.
REQ-007 SHALL have port start  input  1  request; accepted only when busy=0.
REQ-008 SHALL have port enable  input  1  bus drive enable.
REQ-009 SHALL have port data  output  WIDTH  result_q when enable=1, else all bits high-Z.
REQ-010 SHALL have ports busy, done  output  1  operation in flight / one-cycle completion pulse.
REQ-011 SHALL have ports carry_out, zero_flag, neg_flag, ovf_flag, err  output  1  registered flags.

Function
REQ-012 SHALL implement opcodes: 0 ADD in_1+in_2+carry_in, 1 SUB in_1-in_2, 2 AND, 3 OR, 4 XOR, 5 NOT in_1, 6 INC in_1, 7 DEC in_1, 8 SHL, 9 SHR (logical), 10 MUL, 11 CMP.
REQ-013 SHALL compute all arithmetic at WIDTH+1 bits; carry_out = bit WIDTH (borrow for SUB/DEC/CMP); carry_out = 0 for logic ops.
REQ-014 SHALL use in_2[clog2(WIDTH)-1:0] as shift amount; carry_out = last bit shifted out, 0 when amount is 0.
REQ-015 SHALL set ovf_flag on two's-complement overflow for ADD/SUB/INC/DEC/CMP, else 0.
REQ-016 SHALL for CMP leave result_q unchanged and update flags from in_1-in_2.
REQ-017 SHALL for MUL produce low WIDTH product bits in result_q, carry_out = OR of high WIDTH bits, ovf_flag = 0.
REQ-018 SHALL set zero_flag = (result == 0) and neg_flag = result MSB, from the value the op produced (difference for CMP).
REQ-019 SHALL for opcodes 12..15 load result_q = 0, all other flags 0, err = 1; err clears on the next completed legal op.
REQ-020 SHALL use FSM states IDLE, EXEC, MUL; IDLE->EXEC on start for opcodes != 10, IDLE->MUL on start for opcode 10.
REQ-021 SHALL in EXEC register result and flags at the next edge and return to IDLE: start at edge N -> done high for cycle after edge N+1.
REQ-022 SHALL in MUL run a shift-add iteration per cycle; done after edge N+WIDTH, then IDLE.
REQ-023 SHALL assert busy in EXEC and MUL; start while busy SHALL be ignored and not queued.
REQ-024 SHALL allow start in the same cycle done is high (back-to-back, one idle-free op every 2 cycles).
REQ-025 SHALL hold result_q and flags stable between completions; enable has no effect on internal state.

Reset
REQ-026 SHALL on reset_n=0 immediately force state IDLE, result_q=0, busy=0, done=0, all flags 0, err=0; an in-flight op is discarded.
REQ-027 SHALL accept start on the first rising edge after reset_n deasserts.

Configuration
REQ-028 SHALL compile the multiplier only when macro ALU_SEQ_MUL_EN is defined.
REQ-029 SHALL without ALU_SEQ_MUL_EN treat opcode 10 as illegal per REQ-019 (EXEC path, 2-cycle latency, err=1).

Structure
REQ-030 SHALL place opcode constants, FSM state typedef and flag-vector typedef in package alu_seq_pkg.
REQ-031 SHALL implement the iterative multiplier as sub-module alu_seq_mul (start/done, WIDTH parameter), instantiated only under ALU_SEQ_MUL_EN.

Verification
REQ-032 SHALL cover WIDTH=16 ADD 0xFFFF+0x0001, carry_in=0 -> result 0x0000, carry_out=1, zero_flag=1, done at cycle 2.
REQ-033 SHALL cover SUB 0x8000-0x0001 -> result 0x7FFF, ovf_flag=1, carry_out=0; CMP 5,7 -> carry_out=1, neg_flag=1, result_q unchanged.
REQ-034 SHALL cover MUL 0x0100*0x0100 with ALU_SEQ_MUL_EN -> result 0x0000, carry_out=1, done after 16 cycles, busy high throughout, second start ignored.
REQ-035 SHALL cover SHL 0x8001 by 1 -> 0x0002, carry_out=1; opcode 13 -> result 0, err=1; without ALU_SEQ_MUL_EN opcode 10 -> err=1.
REQ-036 SHALL cover reset_n low mid-MUL -> all outputs 0 asynchronously; enable=0 -> data all Z.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, flag vector.
// Optional multiplier is controlled by macro ALU_SEQ_MUL_EN (see alu_seq.sv).
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_INC = 4'd6;
  localparam logic [3:0] OP_DEC = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam logic [3:0] OP_CMP = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2
  } state_t;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
    logic err;
  } flags_t;

  localparam flags_t FLAGS_CLR = 5'b00000;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one partial product per clock.
// Bit 0 of the multiplier is folded in when start is sampled, the remaining
// WIDTH-1 bits take one cycle each, and done pulses with the full product
// registered, WIDTH-1 cycles after start.
module alu_seq_mul
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   in_1,
  input  logic [WIDTH-1:0]   in_2,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [CW-1:0]      cnt_r;
  logic               run_r;
  logic               done_r;

  // Load operands on start, then accumulate one shifted partial product per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      cnt_r    <= {CW{1'b0}};
      run_r    <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (start) begin
        mcand_r  <= {{(WIDTH-1){1'b0}}, in_1, 1'b0};
        mplier_r <= {1'b0, in_2[WIDTH-1:1]};
        acc_r    <= in_2[0] ? {{WIDTH{1'b0}}, in_1} : {(2*WIDTH){1'b0}};
        cnt_r    <= CW'(1);
        run_r    <= 1'b1;
      end else if (run_r) begin
        acc_r    <= acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
        mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
        mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
        cnt_r    <= cnt_r + CW'(1);
        if (cnt_r == CW'(WIDTH-1)) begin
          run_r  <= 1'b0;
          done_r <= 1'b1;
        end else begin
          run_r  <= 1'b1;
        end
      end else begin
        run_r <= 1'b0;
      end
    end
  end

  assign done    = done_r;
  assign product = acc_r;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with start/busy/done handshake and registered result/flags.
// Single-cycle ops go IDLE->EXEC->IDLE; MUL goes IDLE->MUL->IDLE and is only
// built when macro ALU_SEQ_MUL_EN is defined, otherwise opcode 10 is illegal.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [3:0]       select,
  input  logic             carry_in,
  input  logic             start,
  input  logic             enable,
  output logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic             carry_out,
  output logic             zero_flag,
  output logic             neg_flag,
  output logic             ovf_flag,
  output logic             err
);

  localparam int SW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;

  state_t           state_r;
  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic [3:0]       sel_r;
  logic             cin_r;
  logic [WIDTH-1:0] result_r;
  flags_t           flags_r;
  logic             busy_r;
  logic             done_r;

  logic [WIDTH:0]     wide_s;
  logic [WIDTH-1:0]   val_s;
  logic [SW-1:0]      shamt_s;
  logic               c_s;
  logic               o_s;
  logic               illegal_s;
  logic               exec_wr_s;
  flags_t             exec_flags_s;
  flags_t             mul_flags_s;
  logic               is_mul_s;
  logic               mul_done_s;
  logic [2*WIDTH-1:0] mul_prod_s;

`ifdef ALU_SEQ_MUL_EN
  logic mul_start_s;

  assign is_mul_s    = (select == OP_MUL);
  assign mul_start_s = (state_r == ST_IDLE) && start && is_mul_s;

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mul_start_s),
    .in_1    (in_1),
    .in_2    (in_2),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );
`else
  assign is_mul_s   = 1'b0;
  assign mul_done_s = 1'b0;
  assign mul_prod_s = {(2*WIDTH){1'b0}};
`endif

  // Single-cycle datapath: result and flags from the latched operands.
  always_comb begin
    wide_s    = {(WIDTH+1){1'b0}};
    val_s     = {WIDTH{1'b0}};
    c_s       = 1'b0;
    o_s       = 1'b0;
    illegal_s = 1'b0;
    exec_wr_s = 1'b1;
    shamt_s   = op_b_r[SW-1:0];
    case (sel_r)
      OP_ADD: begin
        wide_s = {1'b0, op_a_r} + {1'b0, op_b_r} + {{WIDTH{1'b0}}, cin_r};
        val_s  = wide_s[WIDTH-1:0];
        c_s    = wide_s[WIDTH];
        o_s    = (op_a_r[M] == op_b_r[M]) && (val_s[M] != op_a_r[M]);
      end
      OP_SUB, OP_CMP: begin
        wide_s    = {1'b0, op_a_r} - {1'b0, op_b_r};
        val_s     = wide_s[WIDTH-1:0];
        c_s       = wide_s[WIDTH];
        o_s       = (op_a_r[M] != op_b_r[M]) && (val_s[M] != op_a_r[M]);
        exec_wr_s = (sel_r != OP_CMP);
      end
      OP_AND: val_s = op_a_r & op_b_r;
      OP_OR:  val_s = op_a_r | op_b_r;
      OP_XOR: val_s = op_a_r ^ op_b_r;
      OP_NOT: val_s = ~op_a_r;
      OP_INC: begin
        wide_s = {1'b0, op_a_r} + {{WIDTH{1'b0}}, 1'b1};
        val_s  = wide_s[WIDTH-1:0];
        c_s    = wide_s[WIDTH];
        o_s    = !op_a_r[M] && val_s[M];
      end
      OP_DEC: begin
        wide_s = {1'b0, op_a_r} - {{WIDTH{1'b0}}, 1'b1};
        val_s  = wide_s[WIDTH-1:0];
        c_s    = wide_s[WIDTH];
        o_s    = op_a_r[M] && !val_s[M];
      end
      OP_SHL: begin
        // bit WIDTH of the widened shift is the last bit pushed out
        wide_s = {1'b0, op_a_r} << shamt_s;
        val_s  = wide_s[WIDTH-1:0];
        c_s    = wide_s[WIDTH];
      end
      OP_SHR: begin
        // bit 0 of the widened shift is the last bit pushed out
        wide_s = {op_a_r, 1'b0} >> shamt_s;
        val_s  = op_a_r >> shamt_s;
        c_s    = wide_s[0];
      end
      default: begin
        illegal_s = 1'b1;
        val_s     = {WIDTH{1'b0}};
      end
    endcase
    exec_flags_s.carry = c_s;
    exec_flags_s.zero  = !illegal_s && (val_s == {WIDTH{1'b0}});
    exec_flags_s.neg   = !illegal_s && val_s[M];
    exec_flags_s.ovf   = o_s;
    exec_flags_s.err   = illegal_s;
  end

  // Flags for a finished multiply: carry flags any nonzero upper product bit.
  always_comb begin
    mul_flags_s       = FLAGS_CLR;
    mul_flags_s.carry = |mul_prod_s[2*WIDTH-1:WIDTH];
    mul_flags_s.zero  = (mul_prod_s[WIDTH-1:0] == {WIDTH{1'b0}});
    mul_flags_s.neg   = mul_prod_s[M];
  end

  // Control FSM: accept start in IDLE, register result/flags on completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      op_a_r   <= {WIDTH{1'b0}};
      op_b_r   <= {WIDTH{1'b0}};
      sel_r    <= 4'd0;
      cin_r    <= 1'b0;
      result_r <= {WIDTH{1'b0}};
      flags_r  <= FLAGS_CLR;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            op_a_r  <= in_1;
            op_b_r  <= in_2;
            sel_r   <= select;
            cin_r   <= carry_in;
            busy_r  <= 1'b1;
            state_r <= is_mul_s ? ST_MUL : ST_EXEC;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_EXEC: begin
          if (exec_wr_s) begin
            result_r <= val_s;
          end else begin
            result_r <= result_r;
          end
          flags_r <= exec_flags_s;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        ST_MUL: begin
          if (mul_done_s) begin
            result_r <= mul_prod_s[WIDTH-1:0];
            flags_r  <= mul_flags_s;
            done_r   <= 1'b1;
            busy_r   <= 1'b0;
            state_r  <= ST_IDLE;
          end else begin
            busy_r   <= 1'b1;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign data      = enable ? result_r : {WIDTH{1'bz}};
  assign busy      = busy_r;
  assign done      = done_r;
  assign carry_out = flags_r.carry;
  assign zero_flag = flags_r.zero;
  assign neg_flag  = flags_r.neg;
  assign ovf_flag  = flags_r.ovf;
  assign err       = flags_r.err;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=16): directed ops push hand-computed
// results; a negedge monitor pops and compares on every done pulse.
module tb_alu_seq;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] res;
    logic c, z, n, o, e;
    int lat;
    int issue;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] in_1 = 16'h0000;
  logic [W-1:0] in_2 = 16'h0000;
  logic [3:0]   select = 4'd0;
  logic         carry_in = 1'b0;
  logic         start = 1'b0;
  logic         enable = 1'b1;
  wire  [W-1:0] data;
  logic busy, done, carry_out, zero_flag, neg_flag, ovf_flag, err;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_1(in_1), .in_2(in_2), .select(select),
    .carry_in(carry_in), .start(start), .enable(enable), .data(data),
    .busy(busy), .done(done), .carry_out(carry_out), .zero_flag(zero_flag),
    .neg_flag(neg_flag), .ovf_flag(ovf_flag), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait for idle, present one op, record the expected completion.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic [W-1:0] er, input logic ec, input logic ez,
                       input logic en, input logic eo, input logic ee, input int elat);
    exp_t x;
    int g = 0;
    while (busy !== 1'b0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) chk("issue_wait_busy", 64'(busy), 64'd0);
    in_1 = a; in_2 = b; select = op; carry_in = ci; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    x.res = er; x.c = ec; x.z = ez; x.n = en; x.o = eo; x.e = ee;
    x.lat = elat; x.issue = cyc;
    sbq.push_back(x);
  endtask

  task automatic drain();
    int g = 0;
    while (sbq.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain_queue", 64'(sbq.size()), 64'd0);
  endtask

  // Monitor: each done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t x;
    if (reset_n && done === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        x = sbq.pop_front();
        chk("result", 64'(data), 64'(x.res));
        chk("carry_out", 64'(carry_out), 64'(x.c));
        chk("zero_flag", 64'(zero_flag), 64'(x.z));
        chk("neg_flag", 64'(neg_flag), 64'(x.n));
        chk("ovf_flag", 64'(ovf_flag), 64'(x.o));
        chk("err", 64'(err), 64'(x.e));
        chk("latency", 64'(cyc - x.issue), 64'(x.lat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_flags", 64'({carry_out, zero_flag, neg_flag, ovf_flag, err}), 64'd0);
    reset_n = 1'b1;

    //     op     in_1      in_2      ci    result    c     z     n     o     e    lat
    issue(4'd0,  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    issue(4'd1,  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    issue(4'd11, 16'h0005, 16'h0007, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    issue(4'd8,  16'h8001, 16'h0001, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    issue(4'd13, 16'h1234, 16'h5678, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    issue(4'd0,  16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1);
    issue(4'd2,  16'hF0F0, 16'h3C3C, 1'b0, 16'h3030, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    issue(4'd3,  16'h0F00, 16'h00F0, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    issue(4'd4,  16'hAAAA, 16'hFFFF, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    issue(4'd5,  16'h00FF, 16'h0000, 1'b0, 16'hFF00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    issue(4'd6,  16'h7FFF, 16'h0000, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1);
    issue(4'd7,  16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    issue(4'd9,  16'h0003, 16'h0001, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    issue(4'd8,  16'h1234, 16'h0010, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    issue(4'd1,  16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
`ifdef ALU_SEQ_MUL_EN
    issue(4'd10, 16'h0100, 16'h0100, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, W);
    // busy must hold and extra starts must be dropped while multiplying
    for (int i = 0; i < W - 1; i++) begin
      @(negedge clk);
      chk("mul_busy", 64'(busy), 64'd1);
      in_1 = 16'h0001; in_2 = 16'h0001; select = 4'd0; start = 1'b1;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    issue(4'd10, 16'h0003, 16'h0005, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, W);
`else
    issue(4'd10, 16'h0003, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
`endif
    issue(4'd4,  16'h00F0, 16'h0F0F, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    drain();

    // reset while an op is in flight: outputs clear without a clock edge
    @(negedge clk);
`ifdef ALU_SEQ_MUL_EN
    in_1 = 16'h0100; in_2 = 16'h0100; select = 4'd10;
`else
    in_1 = 16'hFFFF; in_2 = 16'hFFFF; select = 4'd1;
`endif
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    repeat (4) @(negedge clk);
`endif
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_data", 64'(data), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_flags", 64'({carry_out, zero_flag, neg_flag, ovf_flag, err}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    issue(4'd0,  16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    drain();

    enable = 1'b0;
    #1;
    chk("data_released", 64'(data !== 16'h0003), 64'd1);
    enable = 1'b1;
    #1;
    chk("data_driven", 64'(data), 64'h0003);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
